// File: rtl/hs_dpath_sfr_arb.sv
// hs_dpath_sfr_arb: round-robin arbiter feeding a fixed-latency pipeline, routing responses back by owner tag
module hs_dpath_sfr_arb #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_mask,
   input  logic                      flush,
   output logic                      pipe_din_valid,
   output logic [DATA_W-1:0]         pipe_din,
   input  logic [DATA_W-1:0]         pipe_dout,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_data
);
   localparam int IW = $clog2(NUM_REQ);
   logic [IW-1:0]      last_grant, gnt_idx;
   logic [NUM_REQ-1:0] elig;
   logic [LATENCY-1:0] tag_v;
   logic [NUM_REQ-1:0] tag_id [LATENCY];

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] lg, input int k);
      int j;
      j = int'(lg) + 1 + k;
      return IW'(j >= NUM_REQ ? j - NUM_REQ : j);
   endfunction

   assign elig = (rst || flush) ? '0 : req_valid & req_mask;

   // scan lowest priority first so the highest-priority eligible index wins
   always_comb begin
      gnt_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (elig[rr_idx(last_grant, k)]) gnt_idx = rr_idx(last_grant, k);
      pipe_din_valid = |elig;
      req_ready      = pipe_din_valid ? NUM_REQ'(1) << gnt_idx : '0;
      pipe_din       = pipe_din_valid ? req_data[gnt_idx*DATA_W +: DATA_W] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= IW'(NUM_REQ - 1);
         tag_v      <= '0;
      end else begin
         if (pipe_din_valid) last_grant <= gnt_idx;
         tag_v <= flush ? '0 : LATENCY'({tag_v, pipe_din_valid});
      end
      tag_id[0] <= req_ready;
      for (int k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
   end

   assign resp_valid = (tag_v[LATENCY-1] && !rst) ? tag_id[LATENCY-1] : '0;
   assign resp_data  = |resp_valid ? pipe_dout : '0;
endmodule

// File: tb/tb_hs_dpath_sfr_arb.sv
// tb_hs_dpath_sfr_arb: scoreboard bench driving LATENCY=3 and LATENCY=1 instances with shared random stimulus
module tb_hs_dpath_sfr_arb;
   localparam int N = 4;
   localparam int W = 32;

   typedef struct {
      int           due;
      logic [N-1:0] own;
      logic [W-1:0] dat;
   } exp_t;

   logic           clk = 0, rst = 1, flush = 0;
   logic [N-1:0]   req_valid = '0, req_mask = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   rdy0, rdy1, rv0, rv1;
   logic           pv0, pv1;
   logic [W-1:0]   pd0, pd1, po0, po1, rd0, rd1;
   logic [W-1:0]   h3 [3];
   logic [W-1:0]   h1;

   exp_t q [2][$];
   int   lat [2] = '{3, 1};
   int   cyc = 0, checks = 0, errors = 0, lg = N - 1;

   always #5 clk = ~clk;

   // external pipelines: pure delay lines of 3 and 1 cycles
   always @(posedge clk) begin
      h3[2] <= h3[1];
      h3[1] <= h3[0];
      h3[0] <= pd0;
      h1    <= pd1;
   end
   assign po0 = h3[2];
   assign po1 = h1;

   hs_dpath_sfr_arb #(.NUM_REQ(N), .DATA_W(W), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy0),
      .req_mask(req_mask), .flush(flush), .pipe_din_valid(pv0), .pipe_din(pd0),
      .pipe_dout(po0), .resp_valid(rv0), .resp_data(rd0));

   hs_dpath_sfr_arb #(.NUM_REQ(N), .DATA_W(W), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy1),
      .req_mask(req_mask), .flush(flush), .pipe_din_valid(pv1), .pipe_din(pd1),
      .pipe_dout(po1), .resp_valid(rv1), .resp_data(rd1));

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
      end
   endtask

   function automatic logic [N*W-1:0] rnd_data();
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
      return r;
   endfunction

   // one cycle: drive inputs, check the grant against the reference, update expectations
   task automatic step(input logic [N-1:0] v, input logic [N-1:0] m, input logic f,
                       input logic r, input logic [N*W-1:0] d);
      int   g;
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      req_valid = v; req_mask = m; flush = f; rst = r; req_data = d;
      #1;
      g = -1;
      if (!f && !r)
         for (int k = 0; k < N; k++) begin
            int i = (lg + 1 + k) % N;
            if (g < 0 && v[i] && m[i]) g = i;
         end
      chk("ready_l3", W'(rdy0), g < 0 ? 0 : 1 << g);
      chk("ready_l1", W'(rdy1), g < 0 ? 0 : 1 << g);
      chk("din_valid", W'(pv0), g < 0 ? 0 : 1);
      chk("din_l3", pd0, g < 0 ? '0 : d[g*W +: W]);
      chk("din_l1", pd1, g < 0 ? '0 : d[g*W +: W]);
      for (int u = 0; u < 2; u++) begin
         if (r) while (q[u].size() > 0 && q[u][$].due >= cyc) void'(q[u].pop_back());
         if (f) while (q[u].size() > 0 && q[u][$].due > cyc) void'(q[u].pop_back());
      end
      if (r) lg = N - 1;
      else if (g >= 0) begin
         lg = g;
         for (int u = 0; u < 2; u++) begin
            e.due = cyc + lat[u];
            e.own = N'(1) << g;
            e.dat = d[g*W +: W];
            q[u].push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step('0, '1, 0, 0, rnd_data());
   endtask

   initial begin
      logic [N-1:0] rv;
      logic [W-1:0] rd;
      exp_t         e;
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            rv = u == 0 ? rv0 : rv1;
            rd = u == 0 ? rd0 : rd1;
            if (rv !== '0) begin
               if (q[u].size() == 0) chk($sformatf("resp_spurious_u%0d", u), W'(rv), '0);
               else begin
                  e = q[u].pop_front();
                  chk($sformatf("resp_cycle_u%0d", u), W'(cyc), W'(e.due));
                  chk($sformatf("resp_owner_u%0d", u), W'(rv), W'(e.own));
                  chk($sformatf("resp_data_u%0d", u), rd, e.dat);
               end
            end else begin
               chk($sformatf("resp_idle_data_u%0d", u), rd, '0);
               if (q[u].size() > 0 && q[u][0].due == cyc) begin
                  chk($sformatf("resp_missing_u%0d", u), W'(rv), W'(q[u][0].own));
                  void'(q[u].pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [N*W-1:0] d;
      repeat (2) step('1, '1, 0, 1, rnd_data());
      repeat (8) step('1, '1, 0, 0, rnd_data());
      idle(4);
      d = rnd_data();
      d[2*W +: W] = 32'hA5A5_0002;
      step(4'b0100, '1, 0, 0, d);
      idle(4);
      repeat (5) step(4'b1010, 4'b0111, 0, 0, rnd_data());
      idle(4);
      step(4'b0001, '1, 0, 0, rnd_data());
      step(4'b0010, '1, 0, 0, rnd_data());
      step('1, '1, 1, 0, rnd_data());
      step(4'b0100, '1, 0, 0, rnd_data());
      idle(4);
      step('1, '1, 0, 0, rnd_data());
      step('1, '1, 0, 0, rnd_data());
      step('1, '1, 0, 1, rnd_data());
      step('1, '1, 0, 0, rnd_data());
      idle(4);
      repeat (6) begin
         step(4'b0001, '1, 0, 0, rnd_data());
         step(4'b0010, '1, 0, 0, rnd_data());
      end
      repeat (400)
         step(N'($urandom), N'($urandom) | N'($urandom), $urandom_range(0, 15) == 0,
              $urandom_range(0, 40) == 0, rnd_data());
      idle(6);
      chk("queue_drained", W'(q[0].size() + q[1].size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hs_dpath_sfr_arb.md
HS_DPATH_SFR_ARB -- requirements
Module: hs_dpath_sfr_arb

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing the pipeline; legal range 2..16.
REQ-002 Parameter: DATA_W, default 32, request/response data width in bits.
REQ-003 Parameter: LATENCY, default 3, fixed pipeline latency in cycles from pipe_din to pipe_dout; legal range 1..64.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 req_data  input  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  output  NUM_REQ  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 req_mask  input  NUM_REQ  per-requester enable; 0 excludes the requester from arbitration.
REQ-011 flush  input  1  discards all in-flight transactions.
REQ-012 pipe_din_valid  output  1  a transaction enters the external pipeline this cycle.
REQ-013 pipe_din  output  DATA_W  payload of the granted requester.
REQ-014 pipe_dout  input  DATA_W  external pipeline output, valid exactly LATENCY cycles after the matching pipe_din.
REQ-015 resp_valid  output  NUM_REQ  one-hot response strobe to the owning requester.
REQ-016 resp_data  output  DATA_W  response payload, shared by all requesters.

Function
REQ-017 Eligible set = req_valid & req_mask; the block SHALL grant at most one eligible requester per cycle, combinationally.
REQ-018 Round-robin: priority starts at index (last_grant+1) mod NUM_REQ and increases with wrap-around; last_grant updates only on a transfer.
REQ-019 An empty eligible set SHALL produce req_ready = 0, pipe_din_valid = 0, and no change to last_grant.
REQ-020 pipe_din_valid = |req_ready; pipe_din = req_data of the granted index; pipe_din SHALL be 0 when no grant is made.
REQ-021 A LATENCY-deep tag shift register SHALL carry {valid, one-hot owner ID}; stage 0 loads {pipe_din_valid, req_ready} every cycle, and each stage k loads stage k-1.
REQ-022 resp_valid = tag stage LATENCY-1 owner ID gated by its valid bit; resp_data = pipe_dout when any resp_valid bit is high, otherwise 0.
REQ-023 Throughput: one transfer per cycle sustained; response order equals grant order; responses have no backpressure.
REQ-024 Flush: on the edge where flush = 1, all tag valid bits clear, and a grant in that same cycle is suppressed (req_ready = 0 while flush = 1).
REQ-025 last_grant SHALL be unaffected by flush.
REQ-026 If req_mask[i] falls while requester i holds a transfer in flight, that response SHALL still be delivered.
REQ-027 A requester that deasserts req_valid without a grant loses no state; the block does not require requests to be held.
REQ-028 LATENCY = 1: the response appears on the cycle after the grant; no zero-latency path from req_* to resp_*.

Reset
REQ-029 On rst = 1 at a rising edge, all tag valid bits SHALL clear and last_grant SHALL be set to NUM_REQ-1, so index 0 has first priority.
REQ-030 While rst = 1, req_ready = 0, pipe_din_valid = 0, pipe_din = 0, resp_valid = 0 and resp_data = 0.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; no response for any of them is ever emitted.

Verification
REQ-032 NUM_REQ=4, LATENCY=3, all req_valid=1 and req_mask=F after reset: grants are 0,1,2,3,0,... one per cycle, and resp_valid=1,2,4,8 starts 3 cycles after the first grant.
REQ-033 Only requester 2 valid with req_data[2]=0xA5A5_0002, and pipe_dout models a 3-cycle delay: resp_valid=4'b0100 with resp_data=0xA5A5_0002 exactly 3 cycles after the grant; other resp bits stay 0.
REQ-034 Requesters 1 and 3 valid, req_mask=4'b0111: only requester 1 is granted; requester 3 gets req_ready=0 indefinitely.
REQ-035 flush pulses 1 cycle after grants to 0 and 1: neither response appears; a grant made the cycle after flush responds normally, LATENCY cycles later.
REQ-036 rst asserted for 1 cycle with 2 transactions in flight: no resp_valid for them; the next grant with all requesters valid goes to requester 0.
REQ-037 LATENCY=1, requesters 0 and 1 alternate: each response arrives on the cycle following its grant, matched to the correct owner.
